// File: rtl/int_pkg.sv
// Shared types for the interrupt controller: line count, one-hot line vector, FSM states.
package int_pkg;
    localparam int NLINES = 8;

    typedef logic [NLINES-1:0] line_vec_t;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } int_state_t;
endpackage

// File: rtl/int_ctrl_prio.sv
// Fixed-priority picker: one-hot of the highest set bit, zero for a zero input.
// Latency: combinational. Backpressure: none.
// Build option: none.
module prio_onehot
    import int_pkg::*;
(
    input  line_vec_t vec,
    output line_vec_t hp
);
    always_comb begin
        hp = '0;
        for (int i = 0; i < NLINES; i++) begin
            if (vec[i]) begin
                hp    = '0;
                hp[i] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/int_ctrl.sv
// Eight-line fixed-priority interrupt controller with nested in-service tracking; INT_EDGE_EN selects edge capture.
// Latency: irq to int_req/calli is 2 cycles; reti_vec is combinational from insvc.
// Backpressure: int_req/calli hold until ack; one IDLE cycle always follows ack.
module int_ctrl
    import int_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [NLINES-1:0] irq,
    input  logic              ack,
    input  logic              reti,
    output logic              int_req,
    output logic [NLINES-1:0] calli,
    output logic [NLINES-1:0] reti_vec,
    output logic [NLINES-1:0] pend,
    output logic [NLINES-1:0] insvc
);
    int_state_t state;
    line_vec_t  avail;
    line_vec_t  hp_avail;
    line_vec_t  hp_top;
    line_vec_t  insvc_nxt;
    line_vec_t  pend_nxt;
    logic       eligible;
    logic       take;

    assign avail = pend & ~insvc;

    prio_onehot u_prio_avail (.vec(avail),         .hp(hp_avail));
    prio_onehot u_prio_insvc (.vec(insvc),         .hp(reti_vec));
    prio_onehot u_prio_top   (.vec(avail | insvc), .hp(hp_top));

    // avail and insvc are disjoint, so the overall top line lying in avail
    // is exactly hp(avail) > hp(insvc) with avail non-empty.
    assign eligible = |(hp_top & avail);

    // calli doubles as the frozen selection while in REQ.
    assign take = (state == REQ) && ack;

    assign insvc_nxt = (reti ? (insvc & ~reti_vec) : insvc) | (take ? calli : '0);

`ifdef INT_EDGE_EN
    line_vec_t irq_q;
    assign pend_nxt = (pend & ~(take ? calli : '0)) | (irq & ~irq_q);
`else
    assign pend_nxt = irq;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            int_req <= 1'b0;
            calli   <= '0;
            pend    <= '0;
            insvc   <= '0;
`ifdef INT_EDGE_EN
            irq_q   <= '0;
`endif
        end else begin
            pend  <= pend_nxt;
            insvc <= insvc_nxt;
`ifdef INT_EDGE_EN
            irq_q <= irq;
`endif
            case (state)
                IDLE: begin
                    if (eligible) begin
                        state   <= REQ;
                        int_req <= 1'b1;
                        calli   <= hp_avail;
                    end
                end
                REQ: begin
                    if (ack) begin
                        state   <= IDLE;
                        int_req <= 1'b0;
                        calli   <= '0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    int_req <= 1'b0;
                    calli   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_int_ctrl.sv
// Directed-vector bench for int_ctrl; mode-specific sequences follow INT_EDGE_EN.
module tb_int_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irq;
    logic       ack;
    logic       reti;
    logic       int_req;
    logic [7:0] calli;
    logic [7:0] reti_vec;
    logic [7:0] pend;
    logic [7:0] insvc;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    int_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .irq      (irq),
        .ack      (ack),
        .reti     (reti),
        .int_req  (int_req),
        .calli    (calli),
        .reti_vec (reti_vec),
        .pend     (pend),
        .insvc    (insvc)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},   {7'd0, int_req}, 8'h00);
        chk({tag, "_calli"}, calli,    8'h00);
        chk({tag, "_rvec"},  reti_vec, 8'h00);
        chk({tag, "_pend"},  pend,     8'h00);
        chk({tag, "_insvc"}, insvc,    8'h00);
    endtask

    initial begin
        reset = 1'b0; irq = 8'h00; ack = 1'b0; reti = 1'b0;
        tick(2);
        chk_all_zero("rst");

        // single line
        reset = 1'b1; irq = 8'h04;
        tick();
        chk("t1_pend", pend, 8'h04);
        chk("t1_req_early", {7'd0, int_req}, 8'h00);
        tick();
        chk("t1_req", {7'd0, int_req}, 8'h01);
        chk("t1_calli", calli, 8'h04);
        ack = 1'b1; irq = 8'h00;
        tick();
        ack = 1'b0;
        chk("t1_insvc", insvc, 8'h04);
        chk("t1_pend_clr", pend, 8'h00);
        chk("t1_req_drop", {7'd0, int_req}, 8'h00);
        chk("t1_calli_drop", calli, 8'h00);
        tick();
        reti = 1'b1;
        chk("t1_rvec", reti_vec, 8'h04);
        tick();
        reti = 1'b0;
        chk("t1_insvc_ret", insvc, 8'h00);
        chk("t1_rvec_ret", reti_vec, 8'h00);

        // simultaneous lines: highest first, lower blocked while higher in service
        irq = 8'h81;
        tick(2);
        chk("t2_calli", calli, 8'h80);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("t2_insvc", insvc, 8'h80);
        irq = 8'h01;
        tick(2);
        chk("t2_low_blocked", {7'd0, int_req}, 8'h00);
        reti = 1'b1;
        tick();
        reti = 1'b0;
        chk("t2_insvc_ret", insvc, 8'h00);
        chk("t2_req_idle", {7'd0, int_req}, 8'h00);
        tick();
        chk("t2_req_low", {7'd0, int_req}, 8'h01);
        chk("t2_calli_low", calli, 8'h01);
        ack = 1'b1; irq = 8'h00;
        tick();
        ack = 1'b0;
        chk("t2_insvc_low", insvc, 8'h01);

        // frozen selection, then ack and reti together with insvc=01
        irq = 8'h02;
        tick(2);
        chk("t4_calli", calli, 8'h02);
        irq = 8'h42;
        tick();
        chk("t4_frozen1", calli, 8'h02);
        tick();
        chk("t4_frozen2", calli, 8'h02);
        chk("t4_pend", pend, 8'h42);
        ack = 1'b1; reti = 1'b1; irq = 8'h40;
        tick();
        ack = 1'b0; reti = 1'b0;
        chk("t4_insvc_both", insvc, 8'h02);
        chk("t4_idle_gap", {7'd0, int_req}, 8'h00);
        tick();
        chk("t4_calli_hi", calli, 8'h40);
        ack = 1'b1; irq = 8'h00;
        tick();
        ack = 1'b0;
        chk("t4_insvc_nest", insvc, 8'h42);
        reti = 1'b1;
        tick();
        chk("t4_ret1", insvc, 8'h02);
        tick();
        reti = 1'b0;
        chk("t4_ret2", insvc, 8'h00);

        // nesting
        irq = 8'h08;
        tick(2);
        chk("t3_calli08", calli, 8'h08);
        ack = 1'b1; irq = 8'h00;
        tick();
        ack = 1'b0;
        chk("t3_insvc08", insvc, 8'h08);
        irq = 8'h22;
        tick(2);
        chk("t3_calli20", calli, 8'h20);
        ack = 1'b1; irq = 8'h02;
        tick();
        ack = 1'b0;
        chk("t3_insvc28", insvc, 8'h28);
        tick(2);
        chk("t3_low_blk1", {7'd0, int_req}, 8'h00);
        reti = 1'b1;
        tick();
        reti = 1'b0;
        chk("t3_insvc_ret1", insvc, 8'h08);
        tick(2);
        chk("t3_low_blk2", {7'd0, int_req}, 8'h00);
        reti = 1'b1;
        tick();
        reti = 1'b0;
        chk("t3_insvc_ret2", insvc, 8'h00);
        chk("t3_req_gap", {7'd0, int_req}, 8'h00);
        tick();
        chk("t3_calli02", calli, 8'h02);
        ack = 1'b1; irq = 8'h00;
        tick();
        ack = 1'b0; reti = 1'b1;
        tick();
        reti = 1'b0;
        chk("t3_clean", insvc, 8'h00);

        // reset in the middle of a request
        irq = 8'h10;
        tick(2);
        ack = 1'b1; irq = 8'h00;
        tick();
        ack = 1'b0;
        irq = 8'h26;
        tick(2);
        chk("t5_calli", calli, 8'h20);
        chk("t5_insvc", insvc, 8'h10);
        reset = 1'b0; irq = 8'h00;
        tick();
        chk_all_zero("t5_rst");
        reset = 1'b1;
        tick(2);
        chk("t5_pend_after", pend, 8'h00);
        chk("t5_req_after", {7'd0, int_req}, 8'h00);

`ifndef INT_EDGE_EN
        // level: held line does not re-enter while in service, re-enters after reti
        irq = 8'h04;
        tick(2);
        chk("lv_calli", calli, 8'h04);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("lv_insvc", insvc, 8'h04);
        tick(2);
        chk("lv_no_reenter", {7'd0, int_req}, 8'h00);
        reti = 1'b1;
        tick();
        reti = 1'b0;
        chk("lv_insvc_ret", insvc, 8'h00);
        chk("lv_req_gap", {7'd0, int_req}, 8'h00);
        tick();
        chk("lv_rereq", {7'd0, int_req}, 8'h01);
        chk("lv_recalli", calli, 8'h04);
`else
        // edge: pulse is latched; new rise at ack survives the clear; held level is not recaptured
        irq = 8'h04;
        tick();
        irq = 8'h00;
        tick();
        chk("ed_calli", calli, 8'h04);
        chk("ed_pend_latched", pend, 8'h04);
        ack = 1'b1; irq = 8'h04;
        tick();
        ack = 1'b0;
        chk("ed_set_wins", pend, 8'h04);
        chk("ed_insvc", insvc, 8'h04);
        tick(2);
        chk("ed_no_reenter", {7'd0, int_req}, 8'h00);
        reti = 1'b1;
        tick();
        reti = 1'b0;
        tick();
        chk("ed_rereq", calli, 8'h04);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("ed_pend_clr", pend, 8'h00);
        reti = 1'b1;
        tick();
        reti = 1'b0;
        tick(2);
        chk("ed_held_no_cap", pend, 8'h00);
        chk("ed_held_no_req", {7'd0, int_req}, 8'h00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
